uart_rx: RTL

Byte-wide UART receiver for the SoC's memory-mapped peripheral space; the receive-side counterpart to the UART transmitter that drives `uart_tx_wire` from the data-memory MMIO decode. It samples the asynchronous serial line, recovers 8N1 frames (optional even parity), and holds each received byte in a one-entry buffer. The CPU reads the byte through the data-memory MMIO decode, which acknowledges it. Sticky framing, parity and overrun flags report errors until software clears them.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared SoC constants and types used by the UART receiver and its MMIO decode.
package riscv_pkg;

  // Default bit period: 100 MHz / 115200 baud, shared with the transmitter.
  localparam int UART_CLKS_PER_BIT = 868;

  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0004;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0008;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a parameterised reset value.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops
  // sample their inputs from the same edge and the chain behaves as a pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Byte-wide UART receiver with a one-entry buffer and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_rx
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_rx_state_t   state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic             rx_s, rx_s_d;
  logic             ev_commit, ev_ferr;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_pin),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_pend, par_pend_n, ev_perr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      rx_s_d <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_pend <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      rx_s_d <= rx_s;
`ifdef UART_RX_PARITY_EN
      par_pend <= par_pend_n;
`endif
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    sh_n      = sh;
    ev_commit = 1'b0;
    ev_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_pend_n = par_pend;
    ev_perr    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef UART_RX_PARITY_EN
        par_pend_n = 1'b0;
`endif
        // Only a true 1->0 transition starts a frame; a line stuck low does not.
        if (rx_s_d && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n      = '0;
          par_pend_n = (^sh) ^ rx_s;
          state_n    = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (!rx_s) ev_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_pend) ev_perr = 1'b1;
`endif
          else ev_commit = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A new error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ev_commit && (!rx_valid || rx_ack)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      frame_err <= ev_ferr | (frame_err & ~err_clr);
      overrun   <= (ev_commit & rx_valid & ~rx_ack) | (overrun & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= ev_perr | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
